// File: rtl/half_sub_pkg.sv
// Shared types and constants for the half-subtractor library.
// Each truth-table constant packs one input combination's result as {diff, borrow}.
package half_sub_pkg;

   typedef enum logic [1:0] {
      HS_DATAFLOW = 2'd0,
      HS_BEHAV    = 2'd1,
      HS_STRUCT   = 2'd2
   } hs_style_e;

   // Indexed by the input pair {a, b}.
   localparam logic [1:0] HS_TT_00 = 2'b00;
   localparam logic [1:0] HS_TT_01 = 2'b11;
   localparam logic [1:0] HS_TT_10 = 2'b10;
   localparam logic [1:0] HS_TT_11 = 2'b00;

endpackage : half_sub_pkg

// File: rtl/half_sub_cell.sv
// One combinational half-subtractor lane, built in the style chosen by STYLE.
// All three styles must produce identical results; half_sub compares them.
module half_sub_cell
   import half_sub_pkg::*;
#(
   parameter hs_style_e STYLE = HS_DATAFLOW
) (
   input  logic a,
   input  logic b,
   output logic diff,
   output logic borrow
);

   generate
      if (STYLE == HS_DATAFLOW) begin : g_dataflow
         assign diff   = a ^ b;
         assign borrow = ~a & b;
      end else if (STYLE == HS_BEHAV) begin : g_behav
         logic [1:0] res;

         // NOTE: the default arm assigns res on every path, so no latch is inferred.
         always_comb begin
            case ({a, b})
               2'b00:   res = HS_TT_00;
               2'b01:   res = HS_TT_01;
               2'b10:   res = HS_TT_10;
               2'b11:   res = HS_TT_11;
               default: res = 2'b00;
            endcase
         end

         assign diff   = res[1];
         assign borrow = res[0];
      end else begin : g_struct
         wire a_n;
         wire st_diff;
         wire st_borrow;

         xor u_xor (st_diff, a, b);
         not u_not (a_n, a);
         and u_and (st_borrow, a_n, b);

         assign diff   = st_diff;
         assign borrow = st_borrow;
      end
   endgenerate

endmodule : half_sub_cell

// File: rtl/half_sub.sv
// Registered, lane-parallel half subtractor with a three-way self-check per lane.
// The dataflow result is registered; behavioural and structural copies only feed the check.
module half_sub
   import half_sub_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] diff,
   output logic [WIDTH-1:0] borrow,
   output logic             mismatch,
   output logic             err_sticky
);

   logic [WIDTH-1:0] diff_df;
   logic [WIDTH-1:0] borrow_df;
   logic [WIDTH-1:0] diff_bh;
   logic [WIDTH-1:0] borrow_bh;
   logic [WIDTH-1:0] diff_st;
   logic [WIDTH-1:0] borrow_st;
   logic             mismatch_next;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_lane
         half_sub_cell #(.STYLE(HS_DATAFLOW)) u_df (
            .a      (a[i]),
            .b      (b[i]),
            .diff   (diff_df[i]),
            .borrow (borrow_df[i])
         );

         half_sub_cell #(.STYLE(HS_BEHAV)) u_bh (
            .a      (a[i]),
            .b      (b[i]),
            .diff   (diff_bh[i]),
            .borrow (borrow_bh[i])
         );

         half_sub_cell #(.STYLE(HS_STRUCT)) u_st (
            .a      (a[i]),
            .b      (b[i]),
            .diff   (diff_st[i]),
            .borrow (borrow_st[i])
         );
      end
   endgenerate

   // Only a sampled input can be judged; idle cycles never flag.
   assign mismatch_next = in_valid &
                          (({diff_df, borrow_df} != {diff_bh, borrow_bh}) |
                           ({diff_df, borrow_df} != {diff_st, borrow_st}));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         diff       <= '0;
         borrow     <= '0;
         mismatch   <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         out_valid  <= in_valid;
         mismatch   <= mismatch_next;
         err_sticky <= err_sticky | mismatch_next;
         // Results hold through bubbles so downstream sees a stable last value.
         if (in_valid) begin
            diff   <= diff_df;
            borrow <= borrow_df;
         end
      end
   end

endmodule : half_sub

// File: tb/tb_half_sub.sv
// Directed-vector bench for half_sub: a 1-lane instance for the exhaustive truth table
// and a 4-lane instance for multi-lane, bubble, fault-injection and reset scenarios.
module tb_half_sub;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       a1;
   logic       b1;
   logic [3:0] a4;
   logic [3:0] b4;

   logic       out_valid1;
   logic       diff1;
   logic       borrow1;
   logic       mismatch1;
   logic       err_sticky1;
   logic       out_valid4;
   logic [3:0] diff4;
   logic [3:0] borrow4;
   logic       mismatch4;
   logic       err_sticky4;

   int n_vec;
   int n_err;

   half_sub #(.WIDTH(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .a          (a1),
      .b          (b1),
      .out_valid  (out_valid1),
      .diff       (diff1),
      .borrow     (borrow1),
      .mismatch   (mismatch1),
      .err_sticky (err_sticky1)
   );

   half_sub #(.WIDTH(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .a          (a4),
      .b          (b4),
      .out_valid  (out_valid4),
      .diff       (diff4),
      .borrow     (borrow4),
      .mismatch   (mismatch4),
      .err_sticky (err_sticky4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge; outputs are then stable for checking.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_dut4(input string tag, input logic ov, input logic [3:0] d,
                             input logic [3:0] bo, input logic mm, input logic es);
      check({tag, ".out_valid"},  32'(out_valid4),  32'(ov));
      check({tag, ".diff"},       32'(diff4),       32'(d));
      check({tag, ".borrow"},     32'(borrow4),     32'(bo));
      check({tag, ".mismatch"},   32'(mismatch4),   32'(mm));
      check({tag, ".err_sticky"}, 32'(err_sticky4), 32'(es));
   endtask

   // Exhaustive 1-lane vectors: {a,b} and the hand-derived {diff,borrow}.
   logic [1:0] ex_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
   logic [1:0] ex_out [4] = '{2'b00, 2'b11, 2'b10, 2'b00};

   initial begin
      n_vec    = 0;
      n_err    = 0;
      rst      = 1'b1;
      in_valid = 1'b1;
      a1       = 1'b1;
      b1       = 1'b1;
      a4       = 4'hF;
      b4       = 4'hF;

      // 1. Reset dominates a valid input.
      for (int c = 0; c < 3; c++) begin
         step();
         check_dut4("rst4", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
         check("rst1.out_valid", 32'(out_valid1), 0);
         check("rst1.diff",      32'(diff1),      0);
         check("rst1.borrow",    32'(borrow1),    0);
         check("rst1.err",       32'(err_sticky1), 0);
      end

      // 2. Exhaustive truth table on the 1-lane instance, back to back.
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         a1 = ex_in[k][1];
         b1 = ex_in[k][0];
         step();
         check($sformatf("tt%0d.out_valid", k), 32'(out_valid1), 1);
         check($sformatf("tt%0d.diff", k),      32'(diff1),      32'(ex_out[k][1]));
         check($sformatf("tt%0d.borrow", k),    32'(borrow1),    32'(ex_out[k][0]));
         check($sformatf("tt%0d.mismatch", k),  32'(mismatch1),  0);
      end

      // 3. Four independent lanes covering every combination.
      a4 = 4'b1100;
      b4 = 4'b1010;
      step();
      check_dut4("w4", 1'b1, 4'b0110, 4'b0010, 1'b0, 1'b0);

      // 4. Bubble: the result holds while out_valid drops.
      a4 = 4'b0011;
      b4 = 4'b0101;
      step();
      check_dut4("bub0", 1'b1, 4'b0110, 4'b0100, 1'b0, 1'b0);
      in_valid = 1'b0;
      a4 = 4'b1111;
      b4 = 4'b0000;
      step();
      check_dut4("bub1", 1'b0, 4'b0110, 4'b0100, 1'b0, 1'b0);
      in_valid = 1'b1;
      step();
      check_dut4("bub2", 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0);

      // 5. Corrupt the structural path for exactly one sampled cycle.
      a4 = 4'b1010;
      b4 = 4'b0110;
      force dut4.diff_st = 4'b0011;
      step();
      release dut4.diff_st;
      check_dut4("flt0", 1'b1, 4'b1100, 4'b0100, 1'b1, 1'b1);
      check("flt0.dut1_err", 32'(err_sticky1), 0);
      step();
      check_dut4("flt1", 1'b1, 4'b1100, 4'b0100, 1'b0, 1'b1);
      in_valid = 1'b0;
      step();
      check_dut4("flt2", 1'b0, 4'b1100, 4'b0100, 1'b0, 1'b1);
      rst = 1'b1;
      step();
      check_dut4("flt_rst", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

      // 6. Reset in the middle of a valid stream discards the in-flight input.
      rst      = 1'b0;
      in_valid = 1'b1;
      a4 = 4'b1100;
      b4 = 4'b1010;
      step();
      check_dut4("mid0", 1'b1, 4'b0110, 4'b0010, 1'b0, 1'b0);
      rst = 1'b1;
      a4 = 4'b0001;
      b4 = 4'b0010;
      step();
      check_dut4("mid1", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      rst = 1'b0;
      a4 = 4'b0101;
      b4 = 4'b0011;
      step();
      check_dut4("mid2", 1'b1, 4'b0110, 4'b0010, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_half_sub
